// File: rtl/interrupt_issue_sequencer.sv
// Issue stage between fetch and decode: forwards fetched opcodes one cycle later and,
// on an interrupt request, drains the pipe with NOPs, then pushes the PC and loads the vector.
module interrupt_issue_sequencer #(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [2:0]  NOP_OPCODE   = 3'b101
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_fetch_valid,
    input  logic [2:0]          i_fetch_op_code,
    input  logic [PC_WIDTH-1:0] i_fetch_pc,
    input  logic                i_int_req,
    output logic [2:0]          o_op_code,
    output logic                o_valid,
    output logic                o_interrupt,
    output logic                o_fetch_hold,
    output logic                o_push_pc,
    output logic                o_load_vector,
    output logic [PC_WIDTH-1:0] o_saved_pc,
    output logic                o_busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PUSH   = 2'd2,
        VECTOR = 2'd3
    } state_t;

    state_t             state;
    logic               pending;
    logic               issued;
    logic [CNT_W-1:0]   counter;
    logic               entry_c;

    // Entry needs a request, a real instruction issued since the last return, and no flush.
    assign entry_c = (state == RUN) && !i_stall && pending && issued && !i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= RUN;
            pending       <= 1'b0;
            issued        <= 1'b1;
            counter       <= '0;
            o_saved_pc    <= '0;
            o_op_code     <= NOP_OPCODE;
            o_valid       <= 1'b0;
            o_interrupt   <= 1'b0;
            o_fetch_hold  <= 1'b0;
            o_push_pc     <= 1'b0;
            o_load_vector <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            // Requests merge into one; the flag only drops when the entry is taken.
            pending <= entry_c ? 1'b0 : (pending | i_int_req);

            if (!i_stall) begin
                case (state)
                    RUN: begin
                        if (entry_c) begin
                            o_saved_pc   <= i_fetch_pc;
                            o_op_code    <= NOP_OPCODE;
                            o_valid      <= 1'b0;
                            o_interrupt  <= 1'b1;
                            o_fetch_hold <= 1'b1;
                            o_busy       <= 1'b1;
                            counter      <= CNT_W'(DRAIN_CYCLES - 1);
                            state        <= DRAIN;
                        end else if (i_flush) begin
                            o_op_code <= NOP_OPCODE;
                            o_valid   <= 1'b0;
                        end else begin
                            o_op_code <= i_fetch_valid ? i_fetch_op_code : NOP_OPCODE;
                            o_valid   <= i_fetch_valid;
                            if (i_fetch_valid) begin
                                issued <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        o_op_code <= NOP_OPCODE;
                        o_valid   <= 1'b0;
                        if (counter == '0) begin
                            o_push_pc <= 1'b1;
                            state     <= PUSH;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    PUSH: begin
                        o_push_pc     <= 1'b0;
                        o_load_vector <= 1'b1;
                        state         <= VECTOR;
                    end
                    VECTOR: begin
                        o_load_vector <= 1'b0;
                        o_interrupt   <= 1'b0;
                        o_fetch_hold  <= 1'b0;
                        o_busy        <= 1'b0;
                        issued        <= 1'b0;
                        state         <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interrupt_issue_sequencer.sv
// Bench for interrupt_issue_sequencer: a scripted-frame reference model checked every cycle,
// plus directed literal expectations for the main scenarios.
module tb_interrupt_issue_sequencer;

    localparam int unsigned PW = 32;
    localparam int unsigned D  = 3;
    localparam logic [2:0]  NOP = 3'b101;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0, flush = 1'b0, fv = 1'b0, req = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [PW-1:0] pc = '0;

    logic [2:0]    o_op_code;
    logic          o_valid, o_interrupt, o_fetch_hold, o_push_pc, o_load_vector, o_busy;
    logic [PW-1:0] o_saved_pc;

    int checks = 0;
    int failures = 0;

    interrupt_issue_sequencer #(.PC_WIDTH(PW), .DRAIN_CYCLES(D), .NOP_OPCODE(NOP)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_fetch_valid(fv), .i_fetch_op_code(op), .i_fetch_pc(pc), .i_int_req(req),
        .o_op_code(o_op_code), .o_valid(o_valid), .o_interrupt(o_interrupt),
        .o_fetch_hold(o_fetch_hold), .o_push_pc(o_push_pc), .o_load_vector(o_load_vector),
        .o_saved_pc(o_saved_pc), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Frame layout: {op[2:0], valid, interrupt, fetch_hold, push_pc, load_vector, busy}
    typedef logic [8:0] frame_t;

    function automatic frame_t mk(input logic [2:0] o, input logic v, i, h, p, l, b);
        return {o, v, i, h, p, l, b};
    endfunction

    localparam frame_t F_IDLE   = 9'b101_0_0_0_0_0_0;
    localparam frame_t F_DRAIN  = 9'b101_0_1_1_0_0_1;
    localparam frame_t F_PUSH   = 9'b101_0_1_1_1_0_1;
    localparam frame_t F_VECTOR = 9'b101_0_1_1_0_1_1;

    frame_t dut_f;
    assign dut_f = {o_op_code, o_valid, o_interrupt, o_fetch_hold, o_push_pc, o_load_vector, o_busy};

    // Reference model: an interrupt entry queues the whole fixed sequence of output frames,
    // one per unstalled cycle; normal issue resumes once the queue empties.
    frame_t        m_out;
    logic [PW-1:0] m_saved;
    logic          m_pending, m_issued, m_entry;
    frame_t        script[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = F_IDLE; m_saved = '0; m_pending = 1'b0; m_issued = 1'b1;
            script.delete();
        end else begin
            m_entry = 1'b0;
            if (!stall) begin
                if (script.size() > 0) begin
                    m_out = script.pop_front();
                    if (script.size() == 0) m_issued = 1'b0;
                end else if (m_pending && m_issued && !flush) begin
                    m_entry = 1'b1;
                    m_saved = pc;
                    m_out   = F_DRAIN;
                    for (int k = 0; k < int'(D) - 1; k++) script.push_back(F_DRAIN);
                    script.push_back(F_PUSH);
                    script.push_back(F_VECTOR);
                    script.push_back(F_IDLE);
                end else if (flush) begin
                    m_out = F_IDLE;
                end else begin
                    m_out = mk(fv ? op : NOP, fv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    if (fv) m_issued = 1'b1;
                end
            end
            m_pending = m_entry ? 1'b0 : (m_pending | req);
        end
    end

    task automatic cmp();
        checks++;
        if (dut_f !== m_out || o_saved_pc !== m_saved) begin
            failures++;
            $display("FAIL model t=%0t frame act=%b req=%b saved act=%h req=%h",
                     $time, dut_f, m_out, o_saved_pc, m_saved);
        end
    endtask

    task automatic lit(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=%h req=%h", name, $time, act, exp);
        end
    endtask

    // Drive inputs just after a falling edge, then compare at the next falling edge.
    task automatic cyc(input logic st, fl, v, input logic [2:0] o, input logic [PW-1:0] p,
                       input logic rq);
        stall = st; flush = fl; fv = v; op = o; pc = p; req = rq;
        @(negedge clk);
        cmp();
    endtask

    // Run plain issue until the sequence completes; an expired bound is a failure.
    task automatic finish_seq(input string name);
        int n = 0;
        while ((o_busy !== 1'b0 || m_out[0] !== 1'b0) && n < 30) begin
            cyc(1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0F00, 1'b0);
            n++;
        end
        lit(name, 32'(o_busy), 32'd0);
    endtask

    frame_t expect_seq [6];
    int nop_cnt, push_cnt, lv_cnt;

    initial begin
        expect_seq[0] = F_DRAIN;  expect_seq[1] = F_DRAIN;  expect_seq[2] = F_PUSH;
        expect_seq[3] = F_VECTOR; expect_seq[4] = F_IDLE;   expect_seq[5] = 9'b110_1_0_0_0_0_0;

        repeat (2) @(negedge clk);
        lit("reset_frame", 32'(dut_f), 32'(F_IDLE));
        lit("reset_saved", o_saved_pc, 32'h0);
        rst = 1'b0;

        // Straight issue, one cycle latency
        cyc(0, 0, 1, 3'b011, 32'h10, 0); lit("issue_011", 32'(dut_f), 32'(9'b011_1_0_0_0_0_0));
        cyc(0, 0, 1, 3'b100, 32'h14, 0); lit("issue_100", 32'(dut_f), 32'(9'b100_1_0_0_0_0_0));
        cyc(0, 0, 1, 3'b010, 32'h18, 0); lit("issue_010", 32'(dut_f), 32'(9'b010_1_0_0_0_0_0));
        cyc(0, 0, 0, 3'b111, 32'h1C, 0); lit("issue_bubble", 32'(dut_f), 32'(F_IDLE));

        // Basic interrupt sequence
        cyc(0, 0, 1, 3'b001, 32'h0FC, 1); lit("pre_entry_issue", 32'(o_op_code), 32'd1);
        cyc(0, 0, 1, 3'b110, 32'h100, 0);
        lit("entry_saved", o_saved_pc, 32'h100);
        lit("entry_frame", 32'(dut_f), 32'(F_DRAIN));
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 3'b110, 32'h104, 0);
            lit($sformatf("seq_frame_%0d", k), 32'(dut_f), 32'(expect_seq[k]));
        end

        // Stall mid-drain
        cyc(0, 0, 1, 3'b011, 32'h1FC, 1);
        cyc(0, 0, 1, 3'b011, 32'h200, 0);
        lit("stall_entry_saved", o_saved_pc, 32'h200);
        nop_cnt = 1; push_cnt = 0; lv_cnt = 0;
        cyc(0, 0, 1, 3'b011, 32'h204, 0);
        if (dut_f == F_DRAIN) nop_cnt++;
        cyc(1, 0, 1, 3'b011, 32'h204, 0); lit("stall_frozen_1", 32'(dut_f), 32'(F_DRAIN));
        cyc(1, 0, 1, 3'b011, 32'h204, 0); lit("stall_frozen_2", 32'(dut_f), 32'(F_DRAIN));
        for (int k = 0; k < 20 && o_busy; k++) begin
            cyc(0, 0, 1, 3'b011, 32'h204, 0);
            if (dut_f == F_DRAIN) nop_cnt++;
            if (o_push_pc) push_cnt++;
            if (o_load_vector) lv_cnt++;
        end
        lit("stall_nop_count", 32'(nop_cnt), 32'(D));
        lit("stall_push_count", 32'(push_cnt), 32'd1);
        lit("stall_lv_count", 32'(lv_cnt), 32'd1);

        // Request during PUSH: serviced after one valid issue in RUN
        cyc(0, 0, 1, 3'b010, 32'h2F0, 1);
        cyc(0, 0, 1, 3'b010, 32'h300, 0);
        cyc(0, 0, 1, 3'b010, 32'h304, 0);
        cyc(0, 0, 1, 3'b010, 32'h304, 0);
        cyc(0, 0, 1, 3'b010, 32'h304, 0); lit("nest_in_push", 32'(o_push_pc), 32'd1);
        cyc(0, 0, 1, 3'b010, 32'h304, 1); lit("nest_vector", 32'(o_load_vector), 32'd1);
        cyc(0, 0, 1, 3'b010, 32'h304, 0); lit("nest_return", 32'(dut_f), 32'(F_IDLE));
        cyc(0, 0, 1, 3'b010, 32'h400, 0); lit("nest_one_issue", 32'(dut_f), 32'(9'b010_1_0_0_0_0_0));
        cyc(0, 0, 1, 3'b010, 32'h404, 0);
        lit("nest_second_saved", o_saved_pc, 32'h404);
        lit("nest_second_busy", 32'(o_busy), 32'd1);
        finish_seq("nest_done");

        // Flush while pending defers entry one cycle
        cyc(0, 0, 1, 3'b100, 32'h4F8, 1);
        cyc(0, 1, 1, 3'b100, 32'h500, 0);
        lit("flush_frame", 32'(dut_f), 32'(F_IDLE));
        cyc(0, 0, 1, 3'b100, 32'h504, 0);
        lit("flush_deferred_saved", o_saved_pc, 32'h504);
        lit("flush_deferred_busy", 32'(o_busy), 32'd1);

        // Reset in DRAIN aborts with no push
        cyc(0, 0, 1, 3'b100, 32'h508, 1);
        #2 rst = 1'b1;
        #1 lit("abort_frame", 32'(dut_f), 32'(F_IDLE));
        lit("abort_saved", o_saved_pc, 32'h0);
        @(negedge clk); cmp();
        rst = 1'b0;
        push_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 0, 1, 3'b011, 32'h600 + 32'(4 * k), 0);
            if (o_push_pc || o_busy) push_cnt++;
        end
        lit("abort_no_seq", 32'(push_cnt), 32'd0);

        // Randomized traffic checked against the model every cycle
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk); cmp();
                rst = 1'b0;
            end
            cyc(($urandom_range(4) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                3'($urandom), 32'($urandom), ($urandom_range(11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_issue_sequencer.md
Name: interrupt_issue_sequencer

Overview:
- Sits between fetch and the decode control unit; generates the opcode and interrupt inputs that the decoder consumes.
- Normal operation: registers the fetched 3-bit opcode and forwards it to decode one cycle later.
- On an interrupt request:
  - injects NOPs to drain the pipeline;
  - issues a push-PC cycle, then a vector-load cycle;
  - resumes normal issue.

Parameters:
- PC_WIDTH, 32, width of program counter values.
- DRAIN_CYCLES, 3, number of NOP issue cycles before the push-PC cycle (legal range 1..15).
- NOP_OPCODE, 3'b101, opcode the decoder treats as NOP.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_stall  input  1  decode stage stalled; freeze all state and outputs.
- i_flush  input  1  squash the instruction being issued this cycle.
- i_fetch_valid  input  1  fetch presents a valid instruction.
- i_fetch_op_code  input  3  opcode field of the fetched instruction.
- i_fetch_pc  input  PC_WIDTH  PC of the fetched instruction.
- i_int_req  input  1  interrupt request pulse (one or more cycles).
- o_op_code  output  3  opcode to the decode control unit.
- o_valid  output  1  o_op_code is a real (non-injected) instruction.
- o_interrupt  output  1  interrupt sequence in progress (decoder i_interrupt).
- o_fetch_hold  output  1  fetch must hold its PC and instruction.
- o_push_pc  output  1  one-cycle command to push o_saved_pc on the stack.
- o_load_vector  output  1  one-cycle command to load the interrupt vector into PC.
- o_saved_pc  output  PC_WIDTH  return address captured at interrupt entry.
- o_busy  output  1  state is not RUN.

Behaviour:
- All outputs are registered.
- Reset (async, on i_reset=1):
  - state=RUN, pending=0, counter=0, o_saved_pc=0;
  - o_op_code=NOP_OPCODE;
  - o_valid, o_interrupt, o_fetch_hold, o_push_pc, o_load_vector, o_busy all 0.
  - Reset mid-sequence aborts the sequence with no push or vector pulse.
- Pending flag:
  - Set on any clock edge with i_int_req=1, regardless of state or stall.
  - Cleared only on the RUN->DRAIN transition.
  - Multiple requests before service merge into one.
- Stall: with i_stall=1, state, counter and all outputs hold their values. Only the pending flag may change.
- RUN, i_stall=0:
  - If pending=1 and i_flush=0 (interrupt entry):
    - o_saved_pc<=i_fetch_pc; this instruction is not issued and is re-executed on return.
    - o_op_code<=NOP, o_valid<=0, o_interrupt<=1, o_fetch_hold<=1;
    - counter<=DRAIN_CYCLES-1; go to DRAIN.
  - Else if i_flush=1: o_op_code<=NOP, o_valid<=0. Any pending entry is deferred to the next unstalled cycle.
  - Else: o_op_code<=(i_fetch_valid ? i_fetch_op_code : NOP), o_valid<=i_fetch_valid.
  - Latency fetch->o_op_code is 1 cycle.
- DRAIN:
  - Outputs: NOP, o_valid=0, o_interrupt=1, o_fetch_hold=1.
  - If counter==0: go to PUSH and set o_push_pc<=1. Otherwise decrement counter.
  - Total NOP cycles emitted = DRAIN_CYCLES.
- PUSH:
  - o_push_pc is high for exactly one unstalled cycle.
  - Next: o_push_pc<=0, o_load_vector<=1, go to VECTOR.
- VECTOR:
  - o_load_vector is high for exactly one unstalled cycle.
  - Next: o_load_vector<=0, o_interrupt<=0, o_fetch_hold<=0, go to RUN.
- i_flush is ignored in DRAIN, PUSH and VECTOR.
- Nested requests:
  - A request during DRAIN/PUSH/VECTOR stays pending.
  - It is serviced only after RUN has issued at least one instruction with o_valid=1; a one-bit "issued since return" flag enforces this.
- o_busy=1 exactly when state is DRAIN, PUSH or VECTOR.

Test Plan:
- Reset release, then fetch opcodes 011, 100, 010 on consecutive valid cycles -> o_op_code 011, 100, 010 each one cycle later; o_valid=1; o_interrupt=0.
- i_int_req pulse with i_fetch_pc=0x100, DRAIN_CYCLES=3 -> next cycle o_saved_pc=0x100, then:
  - 3 cycles NOP with o_interrupt=1;
  - 1 cycle o_push_pc=1;
  - 1 cycle o_load_vector=1;
  - then RUN with o_busy=0.
- i_stall=1 for 2 cycles mid-DRAIN -> all outputs frozen; total NOP count still 3; push-PC and vector pulses each still exactly 1 unstalled cycle wide.
- i_int_req during PUSH -> sequence completes; one valid instruction issued in RUN; then a second entry begins; o_saved_pc = that next fetch PC.
- i_flush=1 with pending=1 in RUN -> NOP issued with o_valid=0; entry occurs the following unstalled cycle.
- Assert i_reset during DRAIN -> outputs immediately zero and o_op_code=101; no o_push_pc pulse; pending cleared.
